// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, ROM word address, IF/ID register.
// Optional perf counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
   parameter int          N         = 64,
   parameter int          IMEM_AW   = 7,
   parameter logic [31:0] NOP_INSTR = 32'h8B1F03FF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [N-1:0]       branch_target,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_q,
   output logic [N-1:0]       pc_ifid,
   output logic [31:0]        instr_ifid,
   output logic               valid_ifid,
   output logic [31:0]        fetch_cnt,
   output logic [31:0]        bubble_cnt
);

   typedef struct packed {
      logic [N-1:0] pc;
      logic [31:0]  instr;
      logic         valid;
   } ifid_t;

   typedef enum logic [1:0] {
      OP_RESET,
      OP_REDIRECT,
      OP_HOLD,
      OP_ADVANCE
   } op_t;

   logic [N-1:0] pc;
   logic [N-1:0] pc_next;
   ifid_t        ifid;
   ifid_t        ifid_next;
   op_t          op;

   // Low target bits are masked off so the PC can never become misaligned.
   logic [N-1:0] target_aligned;
   assign target_aligned = branch_target & ~N'(3);

   always_comb begin
      if (!reset)
         op = OP_RESET;
      else if (branch_taken)
         op = OP_REDIRECT;
      else if (stall)
         op = OP_HOLD;
      else
         op = OP_ADVANCE;
   end

   always_comb begin
      pc_next   = pc;
      ifid_next = ifid;
      unique case (op)
         OP_RESET: begin
            pc_next   = '0;
            ifid_next = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
         end
         OP_REDIRECT: begin
            pc_next         = target_aligned;
            ifid_next.instr = NOP_INSTR;
            ifid_next.valid = 1'b0;
         end
         OP_HOLD: ;
         OP_ADVANCE: begin
            pc_next   = pc + N'(4);
            ifid_next = '{pc: pc, instr: imem_q, valid: 1'b1};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      pc   <= pc_next;
      ifid <= ifid_next;
   end

   assign imem_addr  = pc[IMEM_AW+1:2];
   assign pc_ifid    = ifid.pc;
   assign instr_ifid = ifid.instr;
   assign valid_ifid = ifid.valid;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_q;
   logic [31:0] bubble_q;

   // Saturating: stop at all-ones rather than wrapping back to zero.
   always_ff @(posedge clk) begin
      if (op == OP_RESET) begin
         fetch_q  <= '0;
         bubble_q <= '0;
      end else if (op == OP_ADVANCE) begin
         if (fetch_q != '1) fetch_q <= fetch_q + 32'd1;
      end else begin
         if (bubble_q != '1) bubble_q <= bubble_q + 32'd1;
      end
   end

   assign fetch_cnt  = fetch_q;
   assign bubble_cnt = bubble_q;
`else
   assign fetch_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed literal checks, then randomized traffic
// compared each cycle against a cycle-level behavioural model.
module tb_fetch_stage;

   localparam int          N   = 64;
   localparam int          AW  = 7;
   localparam logic [31:0] NOP = 32'h8B1F03FF;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          stall = 1'b0;
   logic          branch_taken = 1'b0;
   logic [N-1:0]  branch_target = '0;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_q;
   logic [N-1:0]  pc_ifid;
   logic [31:0]   instr_ifid;
   logic          valid_ifid;
   logic [31:0]   fetch_cnt;
   logic [31:0]   bubble_cnt;

   logic [31:0] rom [128];

   int total = 0;
   int bad   = 0;

   fetch_stage #(.N(N), .IMEM_AW(AW), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(imem_addr), .imem_q(imem_q),
      .pc_ifid(pc_ifid), .instr_ifid(instr_ifid), .valid_ifid(valid_ifid),
      .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;
   assign imem_q = rom[imem_addr];

   // Behavioural model: the PC as a plain integer, the ROM indexed by pc/4 mod 128.
   logic [N-1:0] m_pc, m_ifpc;
   logic [31:0]  m_instr, m_fetch, m_bubble;
   logic         m_valid;
   bit           m_ok = 0;

   always @(posedge clk) begin
      if (!reset) begin
         m_pc = 0; m_ifpc = 0; m_instr = NOP; m_valid = 0;
         m_fetch = 0; m_bubble = 0; m_ok = 1;
      end else if (branch_taken) begin
         m_pc = (branch_target / 4) * 4;
         m_instr = NOP; m_valid = 0;
         if (m_bubble != 32'hFFFFFFFF) m_bubble = m_bubble + 1;
      end else if (stall) begin
         if (m_bubble != 32'hFFFFFFFF) m_bubble = m_bubble + 1;
      end else begin
         m_ifpc = m_pc;
         m_instr = rom[(m_pc / 4) % 128];
         m_valid = 1;
         m_pc = m_pc + 4;
         if (m_fetch != 32'hFFFFFFFF) m_fetch = m_fetch + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_ok) begin
         chk("m.imem_addr", 64'(imem_addr), 64'((m_pc / 4) % 128));
         chk("m.pc_ifid", pc_ifid, m_ifpc);
         chk("m.instr_ifid", 64'(instr_ifid), 64'(m_instr));
         chk("m.valid_ifid", 64'(valid_ifid), 64'(m_valid));
`ifdef FETCH_PERF_CNT_EN
         chk("m.fetch_cnt", 64'(fetch_cnt), 64'(m_fetch));
         chk("m.bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`else
         chk("m.fetch_cnt", 64'(fetch_cnt), 64'd0);
         chk("m.bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic ifid(input string name, input logic [63:0] pc, input logic [31:0] ins,
                       input logic v);
      chk({name, ".pc"}, pc_ifid, pc);
      chk({name, ".instr"}, 64'(instr_ifid), 64'(ins));
      chk({name, ".valid"}, 64'(valid_ifid), 64'(v));
   endtask

   initial begin
      for (int i = 0; i < 128; i++) rom[i] = $urandom;
      rom[0] = 32'hF8000001;
      rom[1] = 32'hF8008002;

      // reset state
      step(); step();
      ifid("rst", 64'h0, NOP, 1'b0);
      chk("rst.addr", 64'(imem_addr), 64'd0);
      chk("rst.fcnt", 64'(fetch_cnt), 64'd0);
      chk("rst.bcnt", 64'(bubble_cnt), 64'd0);

      // free-run from PC 0
      reset = 1'b1;
      step();
      ifid("e1", 64'h0, 32'hF8000001, 1'b1);
      chk("e1.addr", 64'(imem_addr), 64'd1);
      step();
      ifid("e2", 64'h4, 32'hF8008002, 1'b1);
      chk("e2.addr", 64'(imem_addr), 64'd2);

      // 3-cycle stall at pc=8
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall.addr", 64'(imem_addr), 64'd2);
         ifid("stall", 64'h4, 32'hF8008002, 1'b1);
      end
      stall = 1'b0;
      step();
      ifid("resume", 64'h8, rom[2], 1'b1);
      chk("resume.addr", 64'(imem_addr), 64'd3);
`ifdef FETCH_PERF_CNT_EN
      chk("resume.bcnt", 64'(bubble_cnt), 64'd3);
      chk("resume.fcnt", 64'(fetch_cnt), 64'd3);
`else
      chk("resume.bcnt", 64'(bubble_cnt), 64'd0);
`endif

      // advance to pc=0x14, then redirect to 0x68
      step(); step();
      chk("pre_br.addr", 64'(imem_addr), 64'd5);
      branch_taken = 1'b1; branch_target = 64'h68;
      step();
      chk("br.addr", 64'(imem_addr), 64'd26);
      ifid("br", 64'h10, NOP, 1'b0);
      branch_taken = 1'b0;
      step();
      ifid("br_tgt", 64'h68, rom[26], 1'b1);

      // redirect overrides stall
      branch_taken = 1'b1; stall = 1'b1; branch_target = 64'h10;
      step();
      chk("brst.addr", 64'(imem_addr), 64'd4);
      chk("brst.valid", 64'(valid_ifid), 64'd0);
      chk("brst.instr", 64'(instr_ifid), 64'(NOP));
      stall = 1'b0;

      // misaligned target drops low bits
      branch_target = 64'h6B;
      step();
      chk("mis.addr", 64'(imem_addr), 64'd26);
      branch_taken = 1'b0;
      step();
      chk("mis.pc", pc_ifid, 64'h68);

      // word-address wrap 0x1FC -> 0x200
      branch_taken = 1'b1; branch_target = 64'h1FC;
      step();
      chk("wrap.addr0", 64'(imem_addr), 64'd127);
      branch_taken = 1'b0;
      step();
      chk("wrap.addr1", 64'(imem_addr), 64'd0);
      ifid("wrap", 64'h1FC, rom[127], 1'b1);

      // reset during stall at pc=0x40
      branch_taken = 1'b1; branch_target = 64'h40;
      step();
      branch_taken = 1'b0; stall = 1'b1; reset = 1'b0;
      step();
      chk("rst2.addr", 64'(imem_addr), 64'd0);
      ifid("rst2", 64'h0, NOP, 1'b0);
      chk("rst2.fcnt", 64'(fetch_cnt), 64'd0);
      chk("rst2.bcnt", 64'(bubble_cnt), 64'd0);
      reset = 1'b1; stall = 1'b0;

      // randomized traffic, checked every cycle by the model compare process
      for (int c = 0; c < 3000; c++) begin
         step();
         reset        = ($urandom_range(0, 99) >= 2);
         stall        = ($urandom_range(0, 99) < 25);
         branch_taken = ($urandom_range(0, 99) < 10);
         if ($urandom_range(0, 1) == 0)
            branch_target = {$urandom, $urandom};
         else
            branch_target = 64'($urandom_range(0, 1023));
      end
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch (IF) stage of the pipelined LEGv8 core. It owns the program counter and drives the word address into the 128-word instruction ROM, whose read data is combinational. Each cycle it captures the returned instruction with its PC into the IF/ID pipeline register. It handles hazard stalls from the decode stage and branch redirects with flush from the memory stage.

## Interface
- `N`, 64, PC and branch-target width.
- `IMEM_AW`, 7, instruction-memory word-address width (128 words).
- `NOP_INSTR`, 32'h8B1F03FF, bubble encoding (ADD XZR,XZR,XZR).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset), sampled on the rising edge of `clk`.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `branch_taken`  in  1  PCSrc from MEM: redirect and flush.
- `branch_target`  in  N  redirect PC; bits [1:0] ignored (treated as 0).
- `imem_addr`  out  IMEM_AW  word address = `pc[IMEM_AW+1:2]`.
- `imem_q`  in  32  instruction returned combinationally for `imem_addr`.
- `pc_ifid`  out  N  PC of the instruction held in IF/ID.
- `instr_ifid`  out  32  instruction held in IF/ID.
- `valid_ifid`  out  1  IF/ID holds a real fetched instruction.
- `fetch_cnt`  out  32  instructions delivered (see Configuration).
- `bubble_cnt`  out  32  bubble/hold cycles (see Configuration).

## Operation
- State consists of the PC register, the IF/ID register {`pc_ifid`, `instr_ifid`, `valid_ifid`}, and optionally the counters.
- `imem_addr` is driven only from the PC register. There is no combinational path from any input to `imem_addr`.
- Update priority on each rising edge: reset > branch_taken > stall > advance.
  - Reset (`reset`=0): pc=0. `pc_ifid`=0, `instr_ifid`=NOP_INSTR, `valid_ifid`=0. Counters=0.
  - Redirect (`branch_taken`=1): pc={branch_target[N-1:2],2'b00}. IF/ID is loaded with a bubble: `instr_ifid`=NOP_INSTR, `valid_ifid`=0, `pc_ifid` keeps its value. A simultaneous `stall` is ignored, because a redirect overrides a stall.
  - Stall (`stall`=1, no branch): pc and all IF/ID fields hold their values.
  - Advance: `pc_ifid`=pc, `instr_ifid`=`imem_q`, `valid_ifid`=1, pc=pc+4.
- PC arithmetic is N-bit modulo 2^N. `imem_addr` wraps modulo 2^IMEM_AW words: PC 0x200 fetches word 0.
- PC bits [1:0] are always 0, so misaligned fetch is impossible.
- Bubbles carry `valid_ifid`=0. Downstream stages must not commit state for them.

## Timing
- Fetch latency: the instruction at PC p (fetched while pc=p in cycle t) appears on `instr_ifid` in cycle t+1.
- Redirect: `branch_taken` sampled in cycle t gives pc=target in t+1 and a bubble in IF/ID in t+1. The target instruction appears in IF/ID at t+2.
- Stall: `stall` high for k cycles holds IF/ID and pc for exactly k cycles. Advance resumes on the first edge where stall=0.
- Reset asserted mid-stream takes effect on the next edge regardless of `stall`/`branch_taken`. First valid instruction (PC 0) appears one edge after `reset` is released.
- Every output is registered or derived only from registers.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_cnt` increments on every advance edge.
  - `bubble_cnt` increments on every redirect or stall edge.
  - Both are 32-bit and saturate at 32'hFFFFFFFF.
  - Both clear on reset.
- `FETCH_PERF_CNT_EN` undefined: no counter registers exist; `fetch_cnt` and `bubble_cnt` are tied to 0. All other behaviour is identical.

## Test plan
- Reset then free-run with ROM word0=F8000001, word1=F8008002: edge 1 gives IF/ID {pc 0, F8000001, valid 1}; edge 2 gives {pc 4, F8008002, 1}; `imem_addr` steps 0,1,2.
- Stall held 3 cycles while pc=8: `imem_addr` stays 2 and IF/ID unchanged for 3 edges; next edge loads pc 8, pc becomes 0xC; `bubble_cnt`=3 with macro, 0 without.
- `branch_taken`=1 with target 0x68 while pc=0x14: next edge gives pc=0x68, `imem_addr`=26, IF/ID instr 8B1F03FF with valid 0; the edge after gives {pc 0x68, ROM[26], valid 1}.
- `branch_taken` and `stall` both high with target 0x10: redirect wins; pc=0x10 and a bubble is inserted.
- Target 0x6B: pc=0x68 (low bits dropped). PC 0x1FC advances to 0x200: `imem_addr` wraps 127 to 0.
- `reset`=0 asserted during stall with pc=0x40: next edge gives pc=0, `valid_ifid`=0, `instr_ifid`=8B1F03FF, counters 0.
